// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: exception/interrupt/mret decision at writeback, CSR strobes and PC redirect.
// Optional macro TRAP_CTRL_VECTOR_EN enables vectored interrupt targets when mtvec[1:0]==2'b01.
//
// state | meaning
// IDLE  | evaluate writeback instruction, retire or take trap/mret
// ENTER | pulse mepc/mcause/mtval update and MIE clear from latched values
// JUMP  | redirect to trap target
// RET   | restore MIE and redirect to mepc
module trap_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wb_valid,
    input  logic [WIDTH-1:0] wb_pc,
    input  logic [31:0]      wb_inst,
    input  logic [WIDTH-1:0] wb_badaddr,
    input  logic             wb_exc_fetch_mis,
    input  logic             wb_exc_illegal,
    input  logic             wb_ebreak,
    input  logic             wb_ecall,
    input  logic             wb_exc_load_mis,
    input  logic             wb_exc_store_mis,
    input  logic             wb_mret,
    input  logic             mstatus_mie,
    input  logic             mie_sw,
    input  logic             mie_timer,
    input  logic             mie_external,
    input  logic             mip_sw,
    input  logic             mip_timer,
    input  logic             mip_external,
    input  logic [WIDTH-1:0] mtvec,
    input  logic [WIDTH-1:0] mepc,
    output logic             mepc_update,
    output logic             mcause_update,
    output logic             mtval_update,
    output logic [WIDTH-1:0] mepc_in,
    output logic [WIDTH-1:0] mtval_in,
    output logic             trap_type,
    output logic [3:0]       mcause_in,
    output logic             mstatus_mie_clear,
    output logic             mstatus_mie_set,
    output logic             redirect_valid,
    output logic [WIDTH-1:0] redirect_pc,
    output logic             flush,
    output logic             stall,
    output logic             inst_processed
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ENTER = 2'd1,
        S_JUMP  = 2'd2,
        S_RET   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_cause;
    logic             r_type;
    logic [WIDTH-1:0] r_epc;
    logic [WIDTH-1:0] r_tval;
    logic [WIDTH-1:0] r_redirect_hold;

    logic             w_exc;
    logic [3:0]       w_exc_cause;
    logic             w_irq;
    logic [3:0]       w_irq_cause;
    logic [WIDTH-1:0] w_exc_tval;
    logic             w_decide;
    logic             w_trap_take;
    logic             w_mret_take;
    logic [WIDTH-1:0] w_base;
    logic [WIDTH-1:0] w_target;

    always_comb begin
        w_exc       = 1'b1;
        w_exc_cause = 4'd0;
        w_exc_tval  = '0;
        if (wb_exc_fetch_mis) begin
            w_exc_cause = 4'd0;
            w_exc_tval  = wb_badaddr;
        end else if (wb_exc_illegal) begin
            w_exc_cause = 4'd2;
            w_exc_tval  = WIDTH'(wb_inst);
        end else if (wb_ebreak) begin
            w_exc_cause = 4'd3;
        end else if (wb_ecall) begin
            w_exc_cause = 4'd11;
        end else if (wb_exc_load_mis) begin
            w_exc_cause = 4'd4;
            w_exc_tval  = wb_badaddr;
        end else if (wb_exc_store_mis) begin
            w_exc_cause = 4'd6;
            w_exc_tval  = wb_badaddr;
        end else begin
            w_exc = 1'b0;
        end
    end

    always_comb begin
        w_irq       = mstatus_mie;
        w_irq_cause = 4'd0;
        if (mie_external && mip_external) begin
            w_irq_cause = 4'd11;
        end else if (mie_sw && mip_sw) begin
            w_irq_cause = 4'd3;
        end else if (mie_timer && mip_timer) begin
            w_irq_cause = 4'd7;
        end else begin
            w_irq = 1'b0;
        end
    end

    assign w_decide    = (r_state == S_IDLE) && wb_valid;
    assign w_trap_take = w_decide && (w_exc || w_irq);
    assign w_mret_take = w_decide && wb_mret && !w_exc && !w_irq;

    assign w_base = {mtvec[WIDTH-1:2], 2'b00};
`ifdef TRAP_CTRL_VECTOR_EN
    assign w_target = (mtvec[1:0] == 2'b01 && r_type) ? (w_base + (WIDTH'(r_cause) << 2)) : w_base;
`else
    logic w_unused_mode;
    assign w_unused_mode = ^mtvec[1:0];
    assign w_target      = w_base;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_trap_take) begin
                    w_next = S_ENTER;
                end else if (w_mret_take) begin
                    w_next = S_RET;
                end
            end
            S_ENTER: w_next = S_JUMP;
            S_JUMP:  w_next = S_IDLE;
            S_RET:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_cause         <= '0;
            r_type          <= 1'b0;
            r_epc           <= '0;
            r_tval          <= '0;
            r_redirect_hold <= '0;
        end else begin
            r_state <= w_next;
            if (w_trap_take) begin
                r_type  <= !w_exc;
                r_cause <= w_exc ? w_exc_cause : w_irq_cause;
                r_tval  <= w_exc ? w_exc_tval : '0;
                r_epc   <= wb_pc;
            end
            if (redirect_valid) begin
                r_redirect_hold <= redirect_pc;
            end
        end
    end

    // CSR write data is presented from the latched trap record; strobes qualify it in ENTER.
    assign mepc_in           = r_epc;
    assign mtval_in          = r_tval;
    assign mcause_in         = r_cause;
    assign trap_type         = r_type;
    assign mepc_update       = (r_state == S_ENTER);
    assign mcause_update     = (r_state == S_ENTER);
    assign mtval_update      = (r_state == S_ENTER);
    assign mstatus_mie_clear = (r_state == S_ENTER);
    assign mstatus_mie_set   = (r_state == S_RET);
    assign redirect_valid    = (r_state == S_JUMP) || (r_state == S_RET);
    assign redirect_pc       = (r_state == S_JUMP) ? w_target :
                               (r_state == S_RET)  ? mepc : r_redirect_hold;
    assign stall             = (r_state != S_IDLE);
    assign flush             = w_trap_take || w_mret_take || (r_state != S_IDLE);
    assign inst_processed    = w_decide && !w_exc && !w_irq;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: stimulus pushes expected events, a negedge monitor pops and compares.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid;
    logic [31:0] wb_pc, wb_inst, wb_badaddr;
    logic        wb_exc_fetch_mis, wb_exc_illegal, wb_ebreak, wb_ecall, wb_exc_load_mis, wb_exc_store_mis;
    logic        wb_mret;
    logic        mstatus_mie, mie_sw, mie_timer, mie_external, mip_sw, mip_timer, mip_external;
    logic [31:0] mtvec, mepc;
    logic        mepc_update, mcause_update, mtval_update;
    logic [31:0] mepc_in, mtval_in;
    logic        trap_type;
    logic [3:0]  mcause_in;
    logic        mstatus_mie_clear, mstatus_mie_set, redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush, stall, inst_processed;

    trap_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_inst(wb_inst),
        .wb_badaddr(wb_badaddr), .wb_exc_fetch_mis(wb_exc_fetch_mis), .wb_exc_illegal(wb_exc_illegal),
        .wb_ebreak(wb_ebreak), .wb_ecall(wb_ecall), .wb_exc_load_mis(wb_exc_load_mis),
        .wb_exc_store_mis(wb_exc_store_mis), .wb_mret(wb_mret), .mstatus_mie(mstatus_mie),
        .mie_sw(mie_sw), .mie_timer(mie_timer), .mie_external(mie_external), .mip_sw(mip_sw),
        .mip_timer(mip_timer), .mip_external(mip_external), .mtvec(mtvec), .mepc(mepc),
        .mepc_update(mepc_update), .mcause_update(mcause_update), .mtval_update(mtval_update),
        .mepc_in(mepc_in), .mtval_in(mtval_in), .trap_type(trap_type), .mcause_in(mcause_in),
        .mstatus_mie_clear(mstatus_mie_clear), .mstatus_mie_set(mstatus_mie_set),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush), .stall(stall),
        .inst_processed(inst_processed)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  cause;
        logic        flag;
    } ev_t;

    ev_t q_ret[$];
    ev_t q_csr[$];
    ev_t q_red[$];
    ev_t q_fl[$];

    int tests = 0;
    int fails = 0;

    function automatic void check(string name, bit ok, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic ev_t mk(int c, logic [31:0] a, logic [31:0] b, logic [3:0] cause, logic flag);
        ev_t e;
        e.cyc = c; e.a = a; e.b = b; e.cause = cause; e.flag = flag;
        return e;
    endfunction

    // Trap: flush T..T+2 (stall from T+1), CSR strobes at T+1, redirect at T+2.
    function automatic void expect_trap(int t, logic [3:0] cause, logic typ, logic [31:0] epc,
                                        logic [31:0] tval, logic [31:0] target);
        q_fl.push_back(mk(t, 0, 0, 0, 1'b0));
        q_fl.push_back(mk(t + 1, 0, 0, 0, 1'b1));
        q_fl.push_back(mk(t + 2, 0, 0, 0, 1'b1));
        q_csr.push_back(mk(t + 1, epc, tval, cause, typ));
        q_red.push_back(mk(t + 2, target, 0, 0, 1'b0));
    endfunction

    ev_t e;
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (inst_processed) begin
                if (q_ret.size() == 0) check("retire_unexpected", 1'b0, 32'(cyc), 32'd0);
                else begin
                    e = q_ret.pop_front();
                    check("retire_cycle", cyc == e.cyc, 32'(cyc), 32'(e.cyc));
                end
            end
            if ((mepc_update || mtval_update || mstatus_mie_clear) && !mcause_update)
                check("strobe_group", 1'b0, {29'd0, mepc_update, mtval_update, mstatus_mie_clear}, 32'd0);
            if (mcause_update) begin
                if (q_csr.size() == 0) check("csr_unexpected", 1'b0, 32'(cyc), 32'd0);
                else begin
                    e = q_csr.pop_front();
                    check("csr_cycle", cyc == e.cyc, 32'(cyc), 32'(e.cyc));
                    check("mcause_in", mcause_in == e.cause, 32'(mcause_in), 32'(e.cause));
                    check("trap_type", trap_type == e.flag, 32'(trap_type), 32'(e.flag));
                    check("mepc_in", mepc_in == e.a, mepc_in, e.a);
                    check("mtval_in", mtval_in == e.b, mtval_in, e.b);
                    check("csr_strobes", mepc_update && mtval_update && mstatus_mie_clear && !redirect_valid && !mstatus_mie_set,
                          {27'd0, mepc_update, mtval_update, mstatus_mie_clear, redirect_valid, mstatus_mie_set}, 32'h1C);
                end
            end
            if (redirect_valid) begin
                if (q_red.size() == 0) check("redirect_unexpected", 1'b0, redirect_pc, 32'd0);
                else begin
                    e = q_red.pop_front();
                    check("redirect_cycle", cyc == e.cyc, 32'(cyc), 32'(e.cyc));
                    check("redirect_pc", redirect_pc == e.a, redirect_pc, e.a);
                    check("mie_set", mstatus_mie_set == e.flag, 32'(mstatus_mie_set), 32'(e.flag));
                end
            end else if (mstatus_mie_set) begin
                check("mie_set_without_redirect", 1'b0, 32'd1, 32'd0);
            end
            if (flush) begin
                if (q_fl.size() == 0) check("flush_unexpected", 1'b0, 32'(cyc), 32'd0);
                else begin
                    e = q_fl.pop_front();
                    check("flush_cycle", cyc == e.cyc, 32'(cyc), 32'(e.cyc));
                    check("stall", stall == e.flag, 32'(stall), 32'(e.flag));
                end
            end else if (stall) begin
                check("stall_without_flush", 1'b0, 32'd1, 32'd0);
            end
        end
    end

    task automatic clear_wb();
        wb_valid = 0; wb_pc = 0; wb_inst = 0; wb_badaddr = 0;
        wb_exc_fetch_mis = 0; wb_exc_illegal = 0; wb_ebreak = 0; wb_ecall = 0;
        wb_exc_load_mis = 0; wb_exc_store_mis = 0; wb_mret = 0;
        mstatus_mie = 0; mie_sw = 0; mie_timer = 0; mie_external = 0;
        mip_sw = 0; mip_timer = 0; mip_external = 0;
    endtask

    task automatic check_all_zero(string name);
        check({name, "_flags"},
              {mepc_update, mcause_update, mtval_update, mstatus_mie_clear, mstatus_mie_set,
               redirect_valid, flush, stall, inst_processed, trap_type} == 10'd0,
              {22'd0, mepc_update, mcause_update, mtval_update, mstatus_mie_clear, mstatus_mie_set,
               redirect_valid, flush, stall, inst_processed, trap_type}, 32'd0);
        check({name, "_redirect_pc"}, redirect_pc == 32'd0, redirect_pc, 32'd0);
        check({name, "_mepc_in"}, mepc_in == 32'd0, mepc_in, 32'd0);
        check({name, "_mtval_in"}, mtval_in == 32'd0, mtval_in, 32'd0);
        check({name, "_mcause_in"}, mcause_in == 4'd0, 32'(mcause_in), 32'd0);
    endtask

    task automatic start_cycle(output int t);
        @(posedge clk);
        #1;
        t = cyc;
    endtask

    task automatic finish_issue(input int idle_cycles);
        @(posedge clk);
        #1;
        clear_wb();
        repeat (idle_cycles) @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic [31:0] vec_timer, vec_ext;
`ifdef TRAP_CTRL_VECTOR_EN
        vec_timer = 32'h21C;
        vec_ext   = 32'h22C;
`else
        vec_timer = 32'h200;
        vec_ext   = 32'h200;
`endif
        rst_n = 0;
        clear_wb();
        mtvec = 32'h200;
        mepc  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1;
        repeat (2) @(posedge clk);

        // Illegal instruction
        start_cycle(t);
        wb_valid = 1; wb_pc = 32'h100; wb_inst = 32'hFFFF_FFFF; wb_exc_illegal = 1; mtvec = 32'h200;
        expect_trap(t, 4'd2, 1'b0, 32'h100, 32'hFFFF_FFFF, 32'h200);
        finish_issue(3);

        // Timer interrupt, vectored mode
        start_cycle(t);
        mtvec = 32'h201; mstatus_mie = 1; mie_timer = 1; mip_timer = 1; wb_valid = 1; wb_pc = 32'h44;
        expect_trap(t, 4'd7, 1'b1, 32'h44, 32'h0, vec_timer);
        finish_issue(3);

        // External beats software and timer
        start_cycle(t);
        mstatus_mie = 1; mie_sw = 1; mip_sw = 1; mie_external = 1; mip_external = 1;
        mie_timer = 1; mip_timer = 1; wb_valid = 1; wb_pc = 32'h48;
        expect_trap(t, 4'd11, 1'b1, 32'h48, 32'h0, vec_ext);
        finish_issue(3);

        // ecall + external interrupt + mret: exception wins, base target
        start_cycle(t);
        mstatus_mie = 1; mie_external = 1; mip_external = 1; wb_mret = 1; wb_ecall = 1;
        wb_valid = 1; wb_pc = 32'h300;
        expect_trap(t, 4'd11, 1'b0, 32'h300, 32'h0, 32'h200);
        finish_issue(3);

        // Fetch misaligned beats store misaligned
        start_cycle(t);
        mtvec = 32'h200; wb_exc_fetch_mis = 1; wb_exc_store_mis = 1; wb_badaddr = 32'h1003;
        wb_valid = 1; wb_pc = 32'h400;
        expect_trap(t, 4'd0, 1'b0, 32'h400, 32'h1003, 32'h200);
        finish_issue(3);

        // Load misaligned
        start_cycle(t);
        wb_exc_load_mis = 1; wb_badaddr = 32'h2001; wb_valid = 1; wb_pc = 32'h404;
        expect_trap(t, 4'd4, 1'b0, 32'h404, 32'h2001, 32'h200);
        finish_issue(3);

        // ebreak beats ecall; tval is zero
        start_cycle(t);
        wb_ebreak = 1; wb_ecall = 1; wb_badaddr = 32'hDEAD; wb_inst = 32'h0010_0073;
        wb_valid = 1; wb_pc = 32'h408;
        expect_trap(t, 4'd3, 1'b0, 32'h408, 32'h0, 32'h200);
        finish_issue(3);

        // mret
        start_cycle(t);
        mepc = 32'h88; wb_mret = 1; wb_valid = 1; wb_pc = 32'h50;
        q_ret.push_back(mk(t, 0, 0, 0, 1'b0));
        q_fl.push_back(mk(t, 0, 0, 0, 1'b0));
        q_fl.push_back(mk(t + 1, 0, 0, 0, 1'b1));
        q_red.push_back(mk(t + 1, 32'h88, 0, 0, 1'b1));
        finish_issue(2);

        // Pending interrupts with MIE=0: plain retirement follows wb_valid
        start_cycle(t);
        mstatus_mie = 0; mie_timer = 1; mip_timer = 1; mie_external = 1; mip_external = 1;
        wb_valid = 1; wb_pc = 32'h60;
        q_ret.push_back(mk(t, 0, 0, 0, 1'b0));
        q_ret.push_back(mk(t + 1, 0, 0, 0, 1'b0));
        @(posedge clk);
        #1;
        wb_pc = 32'h64;
        @(posedge clk);
        #1;
        wb_valid = 0;
        @(posedge clk);
        #1;
        clear_wb();
        repeat (2) @(posedge clk);

        // Reset during ENTER: outputs drop at once and no redirect follows
        start_cycle(t);
        wb_exc_illegal = 1; wb_inst = 32'h1234_5678; wb_valid = 1; wb_pc = 32'h500;
        q_fl.push_back(mk(t, 0, 0, 0, 1'b0));
        @(posedge clk);
        #1;
        clear_wb();
        rst_n = 0;
        #1;
        check_all_zero("reset_mid");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        repeat (5) @(posedge clk);
        #1;
        check("quiet_after_reset", !redirect_valid && !flush && !stall,
              {29'd0, redirect_valid, flush, stall}, 32'd0);

        @(negedge clk);
        check("pending_events", (q_ret.size() + q_csr.size() + q_red.size() + q_fl.size()) == 0,
              32'(q_ret.size() + q_csr.size() + q_red.size() + q_fl.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Machine-mode trap sequencer between the writeback stage and the CSR file. Detects synchronous exceptions, enabled pending interrupts and `mret` at the writeback instruction boundary. Drives the CSR file's update strobes (mepc, mcause, mtval, mstatus MIE stack), flushes and stalls the pipeline, and issues a single PC redirect to the trap vector or to mepc.

## Interface
- `WIDTH`, 32, datapath width.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `wb_valid` in 1: valid instruction in writeback.
- `wb_pc` in WIDTH: PC of the writeback instruction.
- `wb_inst` in 32: instruction word.
- `wb_badaddr` in WIDTH: faulting address for misaligned fetch, load or store.
- `wb_exc_fetch_mis`, `wb_exc_illegal`, `wb_ebreak`, `wb_ecall`, `wb_exc_load_mis`, `wb_exc_store_mis` in 1 each: exception flags.
- `wb_mret` in 1: mret in writeback.
- `mstatus_mie`, `mie_sw`, `mie_timer`, `mie_external`, `mip_sw`, `mip_timer`, `mip_external` in 1 each: CSR state.
- `mtvec`, `mepc` in WIDTH: CSR state.
- `mepc_update`, `mcause_update`, `mtval_update` out 1: CSR write strobes.
- `mepc_in`, `mtval_in` out WIDTH: CSR write data.
- `trap_type` out 1: 1 = interrupt, 0 = exception.
- `mcause_in` out 4: cause code.
- `mstatus_mie_clear`, `mstatus_mie_set` out 1: MIE stack push / pop.
- `redirect_valid` out 1: one-cycle redirect pulse.
- `redirect_pc` out WIDTH: redirect target.
- `flush` out 1: kill all in-flight instructions, including writeback.
- `stall` out 1: freeze fetch.
- `inst_processed` out 1: instruction retired (minstret increment).

## Operation
- States: IDLE, ENTER, JUMP, RET.
- Decisions are evaluated only in IDLE with `wb_valid=1`. Priority is exception > interrupt > mret.
- Exception priority and cause code:
  - fetch_mis: 0
  - illegal: 2
  - ebreak: 3
  - ecall: 11
  - load_mis: 4
  - store_mis: 6
- Interrupt pending = `mstatus_mie & ((mie_external&mip_external) | (mie_sw&mip_sw) | (mie_timer&mip_timer))`. Priority and cause: external 11 > software 3 > timer 7.
- Trap taken (`trap_take`): latch cause, type, `wb_pc` and tval, then go to ENTER.
  - tval = `wb_badaddr` for causes 0, 4, 6; `wb_inst` for cause 2; 0 otherwise.
  - An interrupt discards the writeback instruction; mepc = its PC.
- ENTER (1 cycle): pulse `mepc_update`, `mcause_update`, `mtval_update` and `mstatus_mie_clear`, all driven from the latched values. Go to JUMP.
- JUMP (1 cycle): `redirect_valid=1`, `redirect_pc` = trap target. Go to IDLE.
- mret taken: go to RET.
- RET (1 cycle): `mstatus_mie_set=1`, `redirect_valid=1`, `redirect_pc=mepc`. Go to IDLE.
- `flush` = `trap_take | mret_take | (state!=IDLE)`.
- `stall` = `(state!=IDLE)`.
- `inst_processed` = IDLE & `wb_valid` & no exception & no interrupt taken. mret counts as retired.
- Interrupts arriving in ENTER, JUMP or RET are ignored. They are re-evaluated in IDLE, where MIE is already cleared after a trap.
- Reset in any state: return to IDLE; all strobes, `redirect_valid`, `flush` and `stall` go to 0; latched registers go to 0.

## Timing
- Reset values: every output is 0, including `redirect_pc`, `mepc_in`, `mtval_in` and `mcause_in`.
- Trap latency: decision at cycle T (flush comb at T); CSR strobes at T+1; redirect at T+2; IDLE again at T+3.
- mret latency: decision at T; MIE restore and redirect at T+1.
- `mepc_in` is 4-byte aligned by the CSR file. This block passes `wb_pc` unmodified.
- At most one strobe group is active per cycle; strobes never overlap a redirect.
- `redirect_pc` is valid only while `redirect_valid=1`, and holds its last value otherwise.

## Configuration
- `TRAP_CTRL_VECTOR_EN` defined:
  - If `mtvec[1:0]==2'b01` and the trap is an interrupt, target = `{mtvec[31:2],2'b00} + 4*cause`.
  - Exceptions always go to the base address.
- Undefined: target = `{mtvec[31:2],2'b00}` for all traps. `mtvec[1:0]` is ignored.

## Test plan
- Illegal instruction:
  - Stimulus: `wb_pc=0x100`, `wb_inst=0xFFFFFFFF`, `mtvec=0x200`.
  - Response: T+1 `mcause_in=2`, `trap_type=0`, `mepc_in=0x100`, `mtval_in=0xFFFFFFFF`, `mstatus_mie_clear=1`; T+2 `redirect_pc=0x200`.
- Vectored timer interrupt (macro on):
  - Stimulus: `mtvec=0x201`, MIE=1, `mie_timer=mip_timer=1`, `wb_pc=0x44`.
  - Response: `mcause_in=7`, `trap_type=1`, `mepc_in=0x44`, `redirect_pc=0x21C`, `inst_processed=0` at T.
- Same stimulus with macro off: `redirect_pc=0x200`.
- Simultaneous ecall + external interrupt + mret flags: exception wins, `mcause_in=11`, `trap_type=0`.
- mret: `mepc=0x88` → T+1 `mstatus_mie_set=1`, `redirect_pc=0x88`, `inst_processed=1` at T.
- Reset mid-sequence: assert `rst_n=0` during ENTER → all outputs 0 immediately; no JUMP redirect after release.
- Pending interrupt with `mstatus_mie=0` → no trap; `inst_processed` follows `wb_valid`.
